// File: rtl/io_bridge_pkg.sv
// Shared address-map constants for the memory-mapped IO bridge.
package io_bridge_pkg;

    localparam logic [31:0] DEF_BASE_ADDR = 32'h1001_0000;
    localparam logic [31:0] WIN_SIZE      = 32'h0000_0200;
    localparam logic [31:0] OUT_STRIDE    = 32'h0000_0010;
    localparam logic [31:0] IN_OFS        = 32'h0000_0100;
    localparam logic [31:0] EDGE_OFS      = 32'h0000_0004;

    // Window offset of channel k inside a register bank starting at bank_ofs.
    function automatic logic [31:0] chan_ofs(input logic [31:0] bank_ofs, input int k);
        return bank_ofs + OUT_STRIDE * 32'(k);
    endfunction

endpackage

// File: rtl/io_debounce.sv
// Two-flop synchronizer followed by a stability-count debouncer for one input channel.
module io_debounce
    import io_bridge_pkg::*;
#(
    parameter int W         = 4,
    parameter int DB_CYCLES = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] raw_i,
    output logic [W-1:0] stable_o
);

    localparam int             CNT_W    = $clog2(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 2);

    logic [W-1:0]     sync1_q, sync2_q, prev_q;
    logic [W-1:0]     stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // The sample that first shows a new value restarts the count at 0, so the
    // stable value takes it on the DB_CYCLES-th identical sample.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if (sync2_q == stable_q) begin
            cnt_d = '0;
        end else if (sync2_q != prev_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d    = '0;
            stable_d = sync2_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            prev_q   <= '0;
            cnt_q    <= '0;
            stable_q <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/io_bridge.sv
// CPU-facing IO window: output channel registers, debounced inputs, optional
// read-to-clear rising-edge capture enabled by macro IO_BRIDGE_EDGE_EN.
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter int          N_OUT     = 2,
    parameter int          N_IN      = 2,
    parameter int          IN_W      = 4,
    parameter int          DB_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 cs,
    input  logic                 sig_w,
    input  logic                 sig_r,
    input  logic [31:0]          wdata,
    input  logic [31:0]          data_fmem,
    input  logic [N_IN*IN_W-1:0] in_raw,
    output logic [31:0]          rdata,
    output logic [N_OUT*32-1:0]  out_data,
    output logic [N_OUT-1:0]     out_stb,
    output logic                 io_hit
);

    logic [31:0]          win_ofs_s;
    logic                 win_hit_s;
    logic [N_OUT-1:0]     wr_sel_s;
    logic [N_IN*IN_W-1:0] lvl_s, edge_s;
    logic [31:0]          rd_io_s, lvl_ext_s, edge_ext_s;
    logic [N_OUT*32-1:0]  out_data_q, out_data_d;
    logic [N_OUT-1:0]     out_stb_q;

    // Addresses below BASE_ADDR wrap to large offsets and fall outside the window.
    assign win_ofs_s = addr - BASE_ADDR;
    assign win_hit_s = (win_ofs_s < WIN_SIZE);
    assign io_hit    = cs & win_hit_s;

    for (genvar g = 0; g < N_IN; g++) begin : g_db
        io_debounce #(
            .W         (IN_W),
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk      (clk),
            .rst      (rst),
            .raw_i    (in_raw[g*IN_W +: IN_W]),
            .stable_o (lvl_s[g*IN_W +: IN_W])
        );
    end

    always_comb begin
        wr_sel_s   = '0;
        rd_io_s    = 32'h0;
        lvl_ext_s  = 32'h0;
        edge_ext_s = 32'h0;
        for (int k = 0; k < N_OUT; k++) begin
            wr_sel_s[k] = io_hit & sig_w & (win_ofs_s == chan_ofs(32'h0, k));
        end
        for (int k = 0; k < N_IN; k++) begin
            lvl_ext_s              = 32'h0;
            edge_ext_s             = 32'h0;
            lvl_ext_s[IN_W-1:0]    = lvl_s[k*IN_W +: IN_W];
            edge_ext_s[IN_W-1:0]   = edge_s[k*IN_W +: IN_W];
            rd_io_s = rd_io_s
                    | ({32{win_ofs_s == chan_ofs(IN_OFS, k)}} & lvl_ext_s)
                    | ({32{win_ofs_s == chan_ofs(IN_OFS + EDGE_OFS, k)}} & edge_ext_s);
        end
    end

    assign rdata = win_hit_s ? rd_io_s : data_fmem;

    always_comb begin
        out_data_d = out_data_q;
        for (int k = 0; k < N_OUT; k++) begin
            if (wr_sel_s[k]) begin
                out_data_d[k*32 +: 32] = wdata;
            end else begin
                out_data_d[k*32 +: 32] = out_data_q[k*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_q <= '0;
            out_stb_q  <= '0;
        end else begin
            out_data_q <= out_data_d;
            out_stb_q  <= wr_sel_s;
        end
    end

    assign out_data = out_data_q;
    assign out_stb  = out_stb_q;

`ifdef IO_BRIDGE_EDGE_EN
    logic [N_IN-1:0]      clr_sel_s;
    logic [N_IN*IN_W-1:0] edge_q, edge_d, lvl_prev_q;

    // A new rising edge wins over a concurrent read-clear of the same bit.
    always_comb begin
        clr_sel_s = '0;
        edge_d    = edge_q;
        for (int k = 0; k < N_IN; k++) begin
            clr_sel_s[k] = io_hit & sig_r & (win_ofs_s == chan_ofs(IN_OFS + EDGE_OFS, k));
            if (clr_sel_s[k]) begin
                edge_d[k*IN_W +: IN_W] = {IN_W{1'b0}};
            end else begin
                edge_d[k*IN_W +: IN_W] = edge_q[k*IN_W +: IN_W];
            end
        end
        edge_d = edge_d | (lvl_s & ~lvl_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            edge_q     <= '0;
            lvl_prev_q <= '0;
        end else begin
            edge_q     <= edge_d;
            lvl_prev_q <= lvl_s;
        end
    end

    assign edge_s = edge_q;
`else
    logic unused_sig_r_s;

    assign edge_s         = '0;
    assign unused_sig_r_s = sig_r;
`endif

endmodule

// File: tb/tb_io_bridge.sv
// Directed bench for io_bridge: bus decode table plus debounce/edge/reset sequences.
module tb_io_bridge;

    localparam logic [31:0] BASE = 32'h1001_0000;
`ifdef IO_BRIDGE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, cs, sig_w, sig_r;
    logic [31:0] addr, wdata, data_fmem, rdata;
    logic [7:0]  in_raw;
    logic [63:0] out_data;
    logic [1:0]  out_stb;
    logic        io_hit;

    int checks = 0;
    int errors = 0;
    int hits;
    int bad;

    typedef struct {
        logic [31:0] addr;
        logic        cs, we, re;
        logic [31:0] wdata, fmem;
        logic [31:0] exp_rdata;
        logic        exp_hit;
        logic [31:0] exp_out0, exp_out1;
        logic [1:0]  exp_stb;
    } vec_t;

    vec_t vecs[15];

    always #5 clk = ~clk;

    io_bridge #(
        .BASE_ADDR (BASE),
        .N_OUT     (2),
        .N_IN      (2),
        .IN_W      (4),
        .DB_CYCLES (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .addr      (addr),
        .cs        (cs),
        .sig_w     (sig_w),
        .sig_r     (sig_r),
        .wdata     (wdata),
        .data_fmem (data_fmem),
        .in_raw    (in_raw),
        .rdata     (rdata),
        .out_data  (out_data),
        .out_stb   (out_stb),
        .io_hit    (io_hit)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic [31:0] a, input logic c, input logic w, input logic r,
                           input logic [31:0] wd, input logic [31:0] fm);
        addr      = a;
        cs        = c;
        sig_w     = w;
        sig_r     = r;
        wdata     = wd;
        data_fmem = fm;
        #1;
    endtask

    initial begin
        //           addr             cs    we    re    wdata          fmem           rdata          hit   out0           out1           stb
        vecs[0]  = '{BASE + 32'h10,  1'b1, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0,         32'h0,         1'b1, 32'h0,         32'hDEAD_BEEF, 2'b10};
        vecs[1]  = '{32'h0,          1'b0, 1'b0, 1'b0, 32'h0,         32'hAAAA_5555, 32'hAAAA_5555, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00};
        vecs[2]  = '{32'h1000_0000,  1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_1234, 32'h0000_1234, 1'b0, 32'h0,         32'hDEAD_BEEF, 2'b00};
        vecs[3]  = '{BASE + 32'h100, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 32'h0,         32'hDEAD_BEEF, 2'b00};
        vecs[4]  = '{BASE,           1'b1, 1'b1, 1'b0, 32'h1111_2222, 32'h0,         32'h0,         1'b1, 32'h1111_2222, 32'hDEAD_BEEF, 2'b01};
        vecs[5]  = '{BASE + 32'h10,  1'b0, 1'b1, 1'b0, 32'h5555_5555, 32'h0,         32'h0,         1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00};
        vecs[6]  = '{BASE + 32'h20,  1'b1, 1'b1, 1'b0, 32'h0000_ABCD, 32'h0,         32'h0,         1'b1, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00};
        vecs[7]  = '{BASE + 32'h1FC, 1'b1, 1'b1, 1'b0, 32'h0000_9999, 32'h0,         32'h0,         1'b1, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00};
        vecs[8]  = '{BASE + 32'h200, 1'b1, 1'b1, 1'b0, 32'h0000_CCCC, 32'h0000_0077, 32'h0000_0077, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00};
        vecs[9]  = '{32'h1000_FFFC,  1'b1, 1'b0, 1'b1, 32'h0,         32'h0000_0088, 32'h0000_0088, 1'b0, 32'h1111_2222, 32'hDEAD_BEEF, 2'b00};
        vecs[10] = '{BASE + 32'h10,  1'b1, 1'b1, 1'b0, 32'h0000_0001, 32'h0,         32'h0,         1'b1, 32'h1111_2222, 32'h0000_0001, 2'b10};
        vecs[11] = '{BASE + 32'h104, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0,         32'h0,         1'b1, 32'h1111_2222, 32'h0000_0001, 2'b00};
        vecs[12] = '{BASE,           1'b1, 1'b1, 1'b0, 32'hCAFE_0001, 32'h0,         32'h0,         1'b1, 32'hCAFE_0001, 32'h0000_0001, 2'b01};
        vecs[13] = '{BASE + 32'h110, 1'b1, 1'b0, 1'b1, 32'h0,         32'h0,         32'h0,         1'b1, 32'hCAFE_0001, 32'h0000_0001, 2'b00};
        vecs[14] = '{BASE + 32'h14,  1'b1, 1'b1, 1'b0, 32'h0BAD_0BAD, 32'h0,         32'h0,         1'b1, 32'hCAFE_0001, 32'h0000_0001, 2'b00};

        rst    = 1'b1;
        in_raw = 8'h00;
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();
        check("reset_out0", out_data[31:0], 32'h0);
        check("reset_out1", out_data[63:32], 32'h0);
        check("reset_stb", {30'h0, out_stb}, 32'h0);
        check("reset_level", rdata, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            set_bus(vecs[i].addr, vecs[i].cs, vecs[i].we, vecs[i].re, vecs[i].wdata, vecs[i].fmem);
            check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("vec%0d_hit", i), {31'h0, io_hit}, {31'h0, vecs[i].exp_hit});
            tick();
            check($sformatf("vec%0d_out0", i), out_data[31:0], vecs[i].exp_out0);
            check($sformatf("vec%0d_out1", i), out_data[63:32], vecs[i].exp_out1);
            check($sformatf("vec%0d_stb", i), {30'h0, out_stb}, {30'h0, vecs[i].exp_stb});
        end

        // Clean step on channel 0: hidden through edge 17, visible from edge 19.
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        in_raw[3:0] = 4'b0101;
        for (int n = 1; n <= 30; n++) begin
            tick();
            if (n <= 17) check($sformatf("step_early_%0d", n), rdata, 32'h0);
            if (n >= 19) check($sformatf("step_late_%0d", n), rdata, 32'h5);
        end
        set_bus(BASE + 32'h104, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        check("edge_first_read", rdata, EDGE_EN ? 32'h5 : 32'h0);
        tick();
        check("edge_after_clear", rdata, 32'h0);

        // Falling step produces no edge; then a rising bit2 with a read-clear every cycle.
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        in_raw[3:0] = 4'b0000;
        repeat (25) tick();
        check("fall_level", rdata, 32'h0);
        set_bus(BASE + 32'h104, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        check("fall_no_edge", rdata, 32'h0);
        in_raw[3:0] = 4'b0100;
        hits = 0;
        bad  = 0;
        for (int n = 0; n < 25; n++) begin
            if (rdata == 32'h4) hits++;
            else if (rdata != 32'h0) bad++;
            tick();
        end
        check("coincide_edge_count", 32'(hits), EDGE_EN ? 32'd1 : 32'd0);
        check("coincide_edge_other", 32'(bad), 32'd0);
        check("coincide_final_read", rdata, 32'h0);
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("bit2_level", rdata, 32'h4);

        // Five-cycle glitch on channel 1 bit 0 must never reach level or edge.
        set_bus(BASE + 32'h110, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        bad = 0;
        in_raw[4] = 1'b1;
        for (int n = 0; n < 30; n++) begin
            tick();
            if (n == 4) in_raw[4] = 1'b0;
            if (rdata != 32'h0) bad++;
        end
        check("glitch_level", 32'(bad), 32'd0);
        set_bus(BASE + 32'h114, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0);
        check("glitch_edge", rdata, 32'h0);

        // Reset clears everything, then a reset mid-debounce restarts the count.
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        in_raw = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_level", rdata, 32'h0);
        check("rst2_out0", out_data[31:0], 32'h0);
        check("rst2_out1", out_data[63:32], 32'h0);
        set_bus(BASE + 32'h104, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        check("rst2_edge", rdata, 32'h0);
        set_bus(BASE + 32'h100, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) tick();
        in_raw[3:0] = 4'b0011;
        repeat (13) tick();
        check("midcount_level", rdata, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int m = 1; m <= 21; m++) begin
            tick();
            if (m <= 17) check($sformatf("restart_early_%0d", m), rdata, 32'h0);
            if (m >= 19) check($sformatf("restart_late_%0d", m), rdata, 32'h3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/io_bridge.md
IO_BRIDGE -- requirements
Module: io_bridge

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h1001_0000; base of the IO window.
REQ-002 SHALL have parameter N_OUT, default 2; number of 32-bit output channels (1..8).
REQ-003 SHALL have parameter N_IN, default 2; number of input channels (1..8).
REQ-004 SHALL have parameter IN_W, default 4; bits per input channel (1..32).
REQ-005 SHALL have parameter DB_CYCLES, default 16; debounce stability count (>=2).
REQ-006 clk  in  1  sole clock, rising edge; the block uses one clock; reset is synchronous and active-high.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 addr  in  32  byte address from CPU.
REQ-009 cs / sig_w / sig_r  in  1 each  chip select, write strobe, read strobe.
REQ-010 wdata  in  32  CPU write data.
REQ-011 data_fmem  in  32  data memory read data.
REQ-012 in_raw  in  N_IN*IN_W  asynchronous raw inputs (buttons/switches); channel k = bits [k*IN_W +: IN_W].
REQ-013 rdata  out  32  read data to CPU.
REQ-014 out_data  out  N_OUT*32  output channel registers (VGA, seg7, ...).
REQ-015 out_stb  out  N_OUT  one-cycle update pulse per output channel.
REQ-016 io_hit  out  1  high when cs=1 and addr lies in [BASE_ADDR, BASE_ADDR+0x1FF]; gates memory writes.

Function
REQ-017 Map: output k at BASE+0x10*k (write); input level k at BASE+0x100+0x10*k (read); edge-capture k at BASE+0x104+0x10*k (read-to-clear).
REQ-018 Write with cs&sig_w to output k SHALL load wdata into out_data[k] on that clock edge; register otherwise holds.
REQ-019 out_stb[k] SHALL be high exactly the one cycle after the loading edge.
REQ-020 Each in_raw bit SHALL pass a 2-flop synchronizer, then the debouncer.
REQ-021 Debouncer per channel: counter clears whenever synchronized value differs from previous synchronized value; when it equals current stable value counter holds at 0; stable value updates after DB_CYCLES consecutive identical differing samples.
REQ-022 A clean step on in_raw SHALL appear on the level register between DB_CYCLES+2 and DB_CYCLES+3 edges later; glitches shorter than DB_CYCLES cycles SHALL never appear.
REQ-023 rdata SHALL be combinational: level read -> zero-extended stable value; edge read -> zero-extended edge bits; other IO-window read -> 0; outside window -> data_fmem.
REQ-024 Edge register bit SHALL set on a 0->1 transition of its stable bit and stay set until cleared.
REQ-025 Edge read with cs&sig_r SHALL return current bits and clear them at the end of that cycle.
REQ-026 Simultaneous clear and new edge on a bit: bit SHALL remain set.
REQ-027 Writes to input/edge addresses and unmapped window addresses SHALL be ignored; reads of output addresses return 0.
REQ-028 cs=0 SHALL suppress all writes, clears and io_hit.

Reset
REQ-029 rst SHALL clear out_data, out_stb, synchronizers, stable values, counters and edge bits to 0 at the next rising edge.
REQ-030 rst asserted mid-debounce SHALL discard the partial count; a pending clear concurrent with rst has no further effect.
REQ-031 rdata reflects reset state combinationally (level/edge reads return 0 during and after reset).

Configuration
REQ-032 Macro IO_BRIDGE_EDGE_EN defined: edge-capture registers and read-to-clear implemented per REQ-024..026.
REQ-033 Macro undefined: no edge flops; edge addresses read 0; reads have no side effects.

Structure
REQ-034 Package io_bridge_pkg SHALL hold default BASE_ADDR, window size 0x200, offsets OUT_STRIDE=0x10, IN_OFS=0x100, EDGE_OFS=0x4.
REQ-035 One sub-module io_debounce (synchronizer + counter + stable register, width IN_W, DB_CYCLES), instantiated N_IN times.

Verification
REQ-036 Reset, then write 32'hDEAD_BEEF to BASE+0x10 -> out_data[1]=DEADBEEF next cycle, out_stb=2'b10 for one cycle, out_data[0]=0.
REQ-037 in_raw ch0 0->4'b0101 held 30 cycles (DB_CYCLES=16) -> read BASE+0x100 returns 5 at cycle 19, 0 before cycle 18.
REQ-038 5-cycle pulse on in_raw ch1 bit0 -> level and edge reads stay 0.
REQ-039 (EDGE_EN) stable 0->1 on ch0 bit2 -> BASE+0x104 reads 4, next read 0; edge coinciding with read -> bit still set next read.
REQ-040 Read addr 0x1000_0000 with data_fmem=32'h1234 -> rdata=0x1234, io_hit=0; write BASE+0x100 -> no register changes.
REQ-041 rst pulsed at counter=10 with in_raw still changed -> level stays 0 until 18 further stable cycles elapse.
